// File: rtl/cla_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// master = producer/consumer side, slave = subtractor side.
interface cla_subtractor_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: diff = A - B - Bin.
// Optional saturation of diff on signed overflow via `define SATURATE_EN.
module cla_subtractor_pipe #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cla_subtractor_pipe_if.slave io
);
    localparam int LO = WIDTH / 2;

    typedef struct packed {
        logic [LO-1:0] lo;
        logic          c;
        logic [LO-1:0] a_hi;
        logic [LO-1:0] nb_hi;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } s2_t;

    // Kogge-Stone prefix adder; returns {carry_out, sum}.
    function automatic logic [LO:0] cla(
        input logic [LO-1:0] x,
        input logic [LO-1:0] y,
        input logic          cin
    );
        logic [LO-1:0] g;
        logic [LO-1:0] p;
        logic [LO-1:0] gg;
        logic [LO-1:0] pp;
        logic [LO-1:0] c;
        g  = x & y;
        p  = x ^ y;
        gg = g;
        pp = p;
        // Descending i keeps gg/pp[i-d] at the previous level's value.
        for (int d = 1; d < LO; d = d * 2) begin
            for (int i = LO - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c[0] = cin;
        for (int i = 1; i < LO; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & cin);
        end
        return {gg[LO-1] | (pp[LO-1] & cin), p ^ c};
    endfunction

    logic s1_valid_q;
    logic s1_valid_d;
    s1_t  s1_q;
    s1_t  s1_d;
    logic s2_valid_q;
    logic s2_valid_d;
    s2_t  s2_q;
    s2_t  s2_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic             s2_fire;
    logic [LO:0]      lo_sum;
    logic [LO:0]      hi_sum;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_raw;

    // Handshake: a stage may move when the one after it can take its beat.
    always_comb begin
        s2_adv  = !s2_valid_q || io.out_ready;
        s1_adv  = !s1_valid_q || s2_adv;
        in_fire = io.in_valid && s1_adv;
        s2_fire = s1_valid_q && s2_adv;
    end

    assign io.in_ready  = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.diff      = s2_q.diff;
    assign io.bout      = s2_q.bout;
    assign io.ovf       = s2_q.ovf;

    // Stage 1: low half of A + ~B + ~Bin, carry the high operands forward.
    always_comb begin
        lo_sum     = cla(io.a[LO-1:0], ~io.b[LO-1:0], ~io.bin);
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (s1_adv) begin
            s1_valid_d = io.in_valid;
        end
        if (in_fire) begin
            s1_d.lo    = lo_sum[LO-1:0];
            s1_d.c     = lo_sum[LO];
            s1_d.a_hi  = io.a[WIDTH-1:LO];
            s1_d.nb_hi = ~io.b[WIDTH-1:LO];
        end
    end

    // Stage 2: high half from the stage-1 carry, then flags.
    always_comb begin
        hi_sum  = cla(s1_q.a_hi, s1_q.nb_hi, s1_q.c);
        raw     = {hi_sum[LO-1:0], s1_q.lo};
        a_msb   = s1_q.a_hi[LO-1];
        b_msb   = ~s1_q.nb_hi[LO-1];
        ovf_raw = (a_msb != b_msb) && (raw[WIDTH-1] != a_msb);
`ifdef SATURATE_EN
        if (ovf_raw) begin
            res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = raw;
        end
`else
        res = raw;
`endif
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_fire) begin
            s2_d.diff = res;
            s2_d.bout = ~hi_sum[LO];
            s2_d.ovf  = ovf_raw;
        end
    end

    // Pipeline registers; reset drops any in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Scoreboard bench for cla_subtractor_pipe: directed cases plus random
// traffic with random backpressure, checked against an arithmetic model.
module tb_cla_subtractor_pipe;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   bp_en = 1'b0;
    exp_t q[$];

    cla_subtractor_pipe_if #(.WIDTH(W)) io ();

    cla_subtractor_pipe #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         bin
    );
        exp_t   e;
        longint ud;
        longint sd;
        ud   = longint'(a) - longint'(b) - longint'(bin);
        sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        e.d  = ud[W-1:0];
        e.bo = (ud < 0);
        e.ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
`ifdef SATURATE_EN
        if (e.ov) e.d = (sd < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin);
        int n;
        n = 0;
        io.in_valid = 1'b1;
        io.a = a;
        io.b = b;
        io.bin = bin;
        forever begin
            @(negedge clk);
            if (io.in_ready && rst_n) begin
                q.push_back(model(a, b, bin));
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no in_ready, required accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Random backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) io.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: stability under stall, then pop and compare on transfer.
    logic         hold_pending = 1'b0;
    logic [W-1:0] held_d;
    logic         held_bo;
    logic         held_ov;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    chk("stall_valid", W'(io.out_valid), W'(1'b1));
                    chk("stall_diff", io.diff, held_d);
                    chk("stall_flags", W'({io.bout, io.ovf}),
                        W'({held_bo, held_ov}));
                end
                if (io.out_valid && io.out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got diff %0h, required none",
                                 io.diff);
                    end else begin
                        e = q.pop_front();
                        chk("diff", io.diff, e.d);
                        chk("bout", W'(io.bout), W'(e.bo));
                        chk("ovf", W'(io.ovf), W'(e.ov));
                    end
                end
                hold_pending = io.out_valid && !io.out_ready;
                held_d = io.diff;
                held_bo = io.bout;
                held_ov = io.ovf;
            end
        end
    end

    initial begin
        int n;
        io.in_valid = 1'b0;
        io.a = '0;
        io.b = '0;
        io.bin = 1'b0;
        io.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", W'(io.out_valid), W'(1'b0));
        chk("rst_diff", io.diff, '0);
        chk("rst_flags", W'({io.bout, io.ovf}), W'(2'b00));
        chk("rst_in_ready", W'(io.in_ready), W'(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 with latency: invisible after accept edge, valid after next.
        send(32'd150, 32'd100, 1'b0);
        chk("t1_valid_edge1", W'(io.out_valid), W'(1'b0));
        @(posedge clk);
        #1;
        chk("t1_valid_edge2", W'(io.out_valid), W'(1'b1));
        chk("t1_diff", io.diff, 32'd50);
        @(posedge clk);
        #1;

        // T2..T4
        send(32'd100, 32'd200, 1'b0);
        send(-32'sd50, -32'sd100, 1'b1);
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // T5: four beats into a stalled consumer.
        io.out_ready = 1'b0;
        fork
            begin
                send(32'd10, 32'd1, 1'b0);
                send(32'd20, 32'd2, 1'b0);
                send(32'd30, 32'd3, 1'b0);
                send(32'd40, 32'd4, 1'b0);
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        chk("t5_in_ready_full", W'(io.in_ready), W'(1'b0));
        chk("t5_queued", W'(q.size()), W'(2));
        chk("t5_head_diff", io.diff, 32'd9);
        io.out_ready = 1'b1;
        wait fork;
        repeat (4) @(posedge clk);
        #1;

        // T6: reset with two beats in flight.
        io.out_ready = 1'b0;
        send(32'd5, 32'd1, 1'b0);
        send(32'd6, 32'd1, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", W'(io.out_valid), W'(1'b0));
        chk("t6_diff", io.diff, '0);
        chk("t6_in_ready", W'(io.in_ready), W'(1'b1));
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        io.out_ready = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (io.out_valid) n++;
        end
        chk("t6_no_stale", W'(n), W'(0));
        chk("t6_ready_after", W'(io.in_ready), W'(1'b1));

        // Random traffic under random backpressure.
        bp_en = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rnd(), rnd(), 1'($urandom_range(0, 1)));
        end
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        bp_en = 1'b0;
        chk("drain_left", W'(q.size()), W'(0));
        #20;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
